// File: rtl/csr_regfile_if.sv
// ============================================================================
// Module   : csr_if
// Purpose  : CSR functional unit <-> CSR register file read/write channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_if;
  logic [11:0] raddr;
  logic [63:0] rdata;
  logic [11:0] waddr;
  logic [63:0] wdata;
  logic        wvalid;

  modport master (output raddr, output waddr, output wdata, output wvalid, input rdata);
  modport slave  (input raddr, input waddr, input wdata, input wvalid, output rdata);
endinterface

`default_nettype wire

// File: rtl/csr_regfile.sv
// ============================================================================
// Module   : csr_regfile
// Purpose  : Machine-mode CSR file with trap/mret updates, counters and IRQ pick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_regfile #(
  parameter logic [63:0] HART_ID     = 64'd0,
  parameter logic [63:0] MTVEC_RESET = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  csr_if.slave        csr_io,
  input  logic [1:0]  retire_cnt_i,
  input  logic        trap_i,
  input  logic [63:0] trap_pc_i,
  input  logic [63:0] trap_cause_i,
  input  logic [63:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        irq_msip_i,
  input  logic        irq_mtip_i,
  input  logic        irq_meip_i,
  output logic [63:0] trap_vec_o,
  output logic [63:0] epc_o,
  output logic        irq_o,
  output logic [63:0] irq_cause_o
);

  localparam logic [11:0] c_MSTATUS   = 12'h300;
  localparam logic [11:0] c_MISA      = 12'h301;
  localparam logic [11:0] c_MIE       = 12'h304;
  localparam logic [11:0] c_MTVEC     = 12'h305;
  localparam logic [11:0] c_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_MEPC      = 12'h341;
  localparam logic [11:0] c_MCAUSE    = 12'h342;
  localparam logic [11:0] c_MTVAL     = 12'h343;
  localparam logic [11:0] c_MIP       = 12'h344;
  localparam logic [11:0] c_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_CYCLE     = 12'hC00;
  localparam logic [11:0] c_INSTRET   = 12'hC02;
  localparam logic [11:0] c_MHARTID   = 12'hF14;
  localparam logic [63:0] c_MISA_VAL  = 64'h8000_0000_0000_1100;
  localparam logic [63:0] c_MIE_MASK  = 64'h0000_0000_0000_0888;
  localparam logic [63:0] c_ALIGN4    = ~64'h3;

  logic        r_status_mie;
  logic        r_status_mpie;
  logic [63:0] r_mie;
  logic [63:0] r_mtvec;
  logic [63:0] r_mscratch;
  logic [63:0] r_mepc;
  logic [63:0] r_mcause;
  logic [63:0] r_mtval;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [63:0] w_mstatus;
  logic [63:0] w_mip;
  logic [63:0] w_pending;
  logic [63:0] w_rdata;
  logic [3:0]  w_code;

  logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch;
  logic w_wr_mepc, w_wr_mcause, w_wr_mtval, w_wr_mcycle, w_wr_minstret;

  assign w_wr_mstatus  = csr_io.wvalid && (csr_io.waddr == c_MSTATUS);
  assign w_wr_mie      = csr_io.wvalid && (csr_io.waddr == c_MIE);
  assign w_wr_mtvec    = csr_io.wvalid && (csr_io.waddr == c_MTVEC);
  assign w_wr_mscratch = csr_io.wvalid && (csr_io.waddr == c_MSCRATCH);
  assign w_wr_mepc     = csr_io.wvalid && (csr_io.waddr == c_MEPC);
  assign w_wr_mcause   = csr_io.wvalid && (csr_io.waddr == c_MCAUSE);
  assign w_wr_mtval    = csr_io.wvalid && (csr_io.waddr == c_MTVAL);
  assign w_wr_mcycle   = csr_io.wvalid && (csr_io.waddr == c_MCYCLE);
  assign w_wr_minstret = csr_io.wvalid && (csr_io.waddr == c_MINSTRET);

  // Per-register priority: trap, then mret, then the commit-time write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status_mie  <= 1'b0;
      r_status_mpie <= 1'b0;
      r_mie         <= 64'd0;
      r_mtvec       <= MTVEC_RESET & c_ALIGN4;
      r_mscratch    <= 64'd0;
      r_mepc        <= 64'd0;
      r_mcause      <= 64'd0;
      r_mtval       <= 64'd0;
      r_mcycle      <= 64'd0;
      r_minstret    <= 64'd0;
    end else begin
      if (trap_i) begin
        r_status_mpie <= r_status_mie;
        r_status_mie  <= 1'b0;
      end else if (mret_i) begin
        r_status_mie  <= r_status_mpie;
        r_status_mpie <= 1'b1;
      end else if (w_wr_mstatus) begin
        r_status_mie  <= csr_io.wdata[3];
        r_status_mpie <= csr_io.wdata[7];
      end

      if (trap_i) begin
        r_mepc   <= trap_pc_i & c_ALIGN4;
        r_mcause <= trap_cause_i;
        r_mtval  <= trap_tval_i;
      end else begin
        if (w_wr_mepc)   r_mepc   <= csr_io.wdata & c_ALIGN4;
        if (w_wr_mcause) r_mcause <= csr_io.wdata;
        if (w_wr_mtval)  r_mtval  <= csr_io.wdata;
      end

      if (w_wr_mie)      r_mie      <= csr_io.wdata & c_MIE_MASK;
      if (w_wr_mtvec)    r_mtvec    <= csr_io.wdata & c_ALIGN4;
      if (w_wr_mscratch) r_mscratch <= csr_io.wdata;

      r_mcycle   <= w_wr_mcycle   ? csr_io.wdata : r_mcycle + 64'd1;
      r_minstret <= w_wr_minstret ? csr_io.wdata : r_minstret + {62'd0, retire_cnt_i};
    end
  end

  assign w_mstatus = {51'd0, 2'b11, 3'd0, r_status_mpie, 3'd0, r_status_mie, 3'd0};
  assign w_mip     = {52'd0, irq_meip_i, 3'd0, irq_mtip_i, 3'd0, irq_msip_i, 3'd0};
  assign w_pending = r_mie & w_mip;

  always_comb begin
    w_rdata = 64'd0;
    case (csr_io.raddr)
      c_MSTATUS:            w_rdata = w_mstatus;
      c_MISA:               w_rdata = c_MISA_VAL;
      c_MIE:                w_rdata = r_mie;
      c_MTVEC:              w_rdata = r_mtvec;
      c_MSCRATCH:           w_rdata = r_mscratch;
      c_MEPC:               w_rdata = r_mepc;
      c_MCAUSE:             w_rdata = r_mcause;
      c_MTVAL:              w_rdata = r_mtval;
      c_MIP:                w_rdata = w_mip;
      c_MCYCLE, c_CYCLE:    w_rdata = r_mcycle;
      c_MINSTRET, c_INSTRET: w_rdata = r_minstret;
      c_MHARTID:            w_rdata = HART_ID;
      default:              w_rdata = 64'd0;
    endcase
  end

  // External beats software beats timer.
  always_comb begin
    w_code = 4'd0;
    if (w_pending[11])     w_code = 4'd11;
    else if (w_pending[3]) w_code = 4'd3;
    else if (w_pending[7]) w_code = 4'd7;
  end

  assign csr_io.rdata = w_rdata;
  assign trap_vec_o   = r_mtvec;
  assign epc_o        = r_mepc;
  assign irq_o        = r_status_mie && (w_pending != 64'd0);
  assign irq_cause_o  = irq_o ? {1'b1, 59'd0, w_code} : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_csr_regfile.sv
// ============================================================================
// Module   : tb_csr_regfile
// Purpose  : Directed and randomized self-checking bench for csr_regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_csr_regfile;

  logic        clk;
  logic        rst;
  logic [1:0]  retire_cnt_i;
  logic        trap_i;
  logic [63:0] trap_pc_i, trap_cause_i, trap_tval_i;
  logic        mret_i;
  logic        irq_msip_i, irq_mtip_i, irq_meip_i;
  logic [63:0] trap_vec_o, epc_o, irq_cause_o;
  logic        irq_o;

  csr_if bus ();

  csr_regfile #(.HART_ID(64'd2), .MTVEC_RESET(64'h8000_0000)) dut (
    .clk(clk), .rst(rst), .csr_io(bus), .retire_cnt_i(retire_cnt_i),
    .trap_i(trap_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i), .irq_msip_i(irq_msip_i),
    .irq_mtip_i(irq_mtip_i), .irq_meip_i(irq_meip_i), .trap_vec_o(trap_vec_o),
    .epc_o(epc_o), .irq_o(irq_o), .irq_cause_o(irq_cause_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Architectural view of the CSR file, one variable per architected field.
  bit          m_valid = 1'b0;
  logic        m_mie_bit, m_mpie_bit;
  logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_cycle, m_instret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pins_mip();
    logic [63:0] v = 64'd0;
    v[3]  = irq_msip_i;
    v[7]  = irq_mtip_i;
    v[11] = irq_meip_i;
    return v;
  endfunction

  function automatic logic [63:0] model_read(input logic [11:0] a);
    logic [63:0] v = 64'd0;
    case (a)
      12'h300: begin v[12:11] = 2'b11; v[7] = m_mpie_bit; v[3] = m_mie_bit; end
      12'h301: v = (64'd2 << 62) | (64'd1 << 12) | (64'd1 << 8);
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = pins_mip();
      12'hB00, 12'hC00: v = m_cycle;
      12'hB02, 12'hC02: v = m_instret;
      12'hF14: v = 64'd2;
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] model_cause();
    logic [63:0] p = m_mie & pins_mip();
    if (!m_mie_bit || p == 64'd0) return 64'd0;
    if (p[11]) return 64'h8000_0000_0000_000B;
    if (p[3])  return 64'h8000_0000_0000_0003;
    return 64'h8000_0000_0000_0007;
  endfunction

  function automatic bit wr(input logic [11:0] a);
    return bus.wvalid && bus.waddr == a;
  endfunction

  task automatic model_step();
    logic n_mie, n_mpie;
    if (rst) begin
      m_valid = 1'b1;
      m_mie_bit = 0; m_mpie_bit = 0; m_mie = 0; m_mtvec = 64'h8000_0000;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cycle = 0; m_instret = 0;
      return;
    end
    n_mie = m_mie_bit; n_mpie = m_mpie_bit;
    if (trap_i) begin n_mpie = m_mie_bit; n_mie = 1'b0; end
    else if (mret_i) begin n_mie = m_mpie_bit; n_mpie = 1'b1; end
    else if (wr(12'h300)) begin n_mie = bus.wdata[3]; n_mpie = bus.wdata[7]; end
    m_mie_bit = n_mie; m_mpie_bit = n_mpie;
    if (trap_i) begin
      m_mepc = {trap_pc_i[63:2], 2'b00}; m_mcause = trap_cause_i; m_mtval = trap_tval_i;
    end else begin
      if (wr(12'h341)) m_mepc = {bus.wdata[63:2], 2'b00};
      if (wr(12'h342)) m_mcause = bus.wdata;
      if (wr(12'h343)) m_mtval = bus.wdata;
    end
    if (wr(12'h304)) m_mie = bus.wdata & 64'h888;
    if (wr(12'h305)) m_mtvec = {bus.wdata[63:2], 2'b00};
    if (wr(12'h340)) m_mscratch = bus.wdata;
    m_cycle   = wr(12'hB00) ? bus.wdata : m_cycle + 1;
    m_instret = wr(12'hB02) ? bus.wdata : m_instret + 64'(retire_cnt_i);
  endtask

  // Advance one clock: compare every output against the model at the falling
  // edge, update the model at the rising edge, then leave 1 ns for new inputs.
  task automatic cycle();
    @(negedge clk);
    if (m_valid) begin
      chk("rdata", bus.rdata, model_read(bus.raddr));
      chk("trap_vec_o", trap_vec_o, m_mtvec);
      chk("epc_o", epc_o, m_mepc);
      chk("irq_cause_o", irq_cause_o, model_cause());
      chk("irq_o", 64'(irq_o), 64'(model_cause() != 64'd0));
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write(input logic [11:0] a, input logic [63:0] d);
    bus.wvalid = 1'b1; bus.waddr = a; bus.wdata = d;
    cycle();
    bus.wvalid = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [63:0] exp);
    bus.raddr = a;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  logic [11:0] addrs [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hC00,
                              12'hC02, 12'hF14, 12'hF11, 12'h7C0};

  initial begin
    rst = 1'b1; retire_cnt_i = 0; trap_i = 0; trap_pc_i = 0; trap_cause_i = 0;
    trap_tval_i = 0; mret_i = 0; irq_msip_i = 0; irq_mtip_i = 0; irq_meip_i = 0;
    bus.raddr = 0; bus.waddr = 0; bus.wdata = 0; bus.wvalid = 0;
    #1;
    cycle(); cycle();
    rst = 1'b0;

    rd("rst_mstatus", 12'h300, 64'h1800);
    rd("rst_mtvec", 12'h305, 64'h8000_0000);
    rd("rst_mhartid", 12'hF14, 64'd2);
    rd("rst_mcycle", 12'hB00, 64'd0);
    chk("rst_epc", epc_o, 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);

    write(12'h305, 64'h1003);
    rd("mtvec_wr", 12'h305, 64'h1000);
    chk("trap_vec_wr", trap_vec_o, 64'h1000);
    irq_msip_i = 1'b1;
    write(12'h344, '1);
    rd("mip_ro", 12'h344, 64'h8);
    irq_msip_i = 1'b0;

    write(12'h300, 64'h8);
    trap_i = 1; trap_pc_i = 64'h2006; trap_cause_i = 64'd2; trap_tval_i = 64'd5;
    write(12'h300, 64'h8);
    trap_i = 0;
    rd("trap_mepc", 12'h341, 64'h2004);
    rd("trap_mcause", 12'h342, 64'd2);
    rd("trap_mtval", 12'h343, 64'd5);
    rd("trap_mstatus", 12'h300, 64'h1880);
    mret_i = 1; cycle(); mret_i = 0;
    rd("mret_mstatus", 12'h300, 64'h1888);

    write(12'h304, 64'h888);
    irq_mtip_i = 1; irq_msip_i = 1;
    #1;
    chk("irq_on", 64'(irq_o), 64'd1);
    chk("irq_cause_msi", irq_cause_o, 64'h8000_0000_0000_0003);
    irq_meip_i = 1;
    #1;
    chk("irq_cause_mei", irq_cause_o, 64'h8000_0000_0000_000B);
    write(12'h300, 64'h0);
    #1;
    chk("irq_off", 64'(irq_o), 64'd0);
    chk("irq_cause_off", irq_cause_o, 64'd0);
    irq_mtip_i = 0; irq_msip_i = 0; irq_meip_i = 0;

    retire_cnt_i = 3;
    repeat (4) cycle();
    retire_cnt_i = 0;
    rd("minstret_12", 12'hB02, 64'd12);
    retire_cnt_i = 2;
    write(12'hB02, 64'd100);
    retire_cnt_i = 0;
    rd("minstret_wr", 12'hB02, 64'd100);

    write(12'hB00, '1);
    rd("mcycle_ones", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle();
    rd("mcycle_wrap", 12'hB00, 64'd0);
    rd("unimpl", 12'h7C0, 64'd0);

    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(99) == 0);
      bus.raddr    = addrs[$urandom_range(15)];
      bus.wvalid   = ($urandom_range(9) < 3);
      bus.waddr    = addrs[$urandom_range(15)];
      bus.wdata    = {$urandom, $urandom};
      trap_i       = ($urandom_range(19) == 0);
      mret_i       = ($urandom_range(19) == 0);
      trap_pc_i    = {$urandom, $urandom};
      trap_cause_i = {$urandom, $urandom};
      trap_tval_i  = {$urandom, $urandom};
      retire_cnt_i = 2'($urandom_range(3));
      irq_msip_i   = 1'($urandom_range(1));
      irq_mtip_i   = 1'($urandom_range(1));
      irq_meip_i   = 1'($urandom_range(1));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode CSR register file, the slave end of `csr_if`. It serves the CSR functional unit's early combinational reads and its at-retirement writes. It also owns trap entry and `mret` state updates, the `mcycle`/`minstret` counters, and the machine interrupt-pending decision consumed by the commit stage.

## Interface
Parameters:
- `HART_ID`, default 0: value returned by `mhartid`.
- `MTVEC_RESET`, default 64'h8000_0000: reset value of `mtvec`.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `csr_io`, slave modport of `csr_if`:
  - `raddr`, in, 12: read address.
  - `rdata`, out, 64: read data, combinational.
  - `waddr`, in, 12: write address.
  - `wdata`, in, 64: write data; already merged for set/clear.
  - `wvalid`, in, 1: commit-time write strobe.
- `retire_cnt_i`, in, 2: instructions retired this cycle (0..3).
- `trap_i`, in, 1: trap taken at commit this cycle.
- `trap_pc_i`, in, 64: PC of the trapping instruction.
- `trap_cause_i`, in, 64: value written to `mcause`.
- `trap_tval_i`, in, 64: value written to `mtval`.
- `mret_i`, in, 1: `mret` retires this cycle.
- `irq_msip_i`, `irq_mtip_i`, `irq_meip_i`, in, 1 each: level interrupt lines.
- `trap_vec_o`, out, 64: `mtvec` base, with bits [1:0] forced to 0.
- `epc_o`, out, 64: current `mepc`.
- `irq_o`, out, 1: interrupt should be taken.
- `irq_cause_o`, out, 64: `mcause` value for that interrupt.

## Operation
Implemented registers (XLEN 64). Any other address reads 0 and ignores writes.
- `mstatus` (0x300): only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
- `misa` (0x301): constant MXL=2 ([63:62]), I[8], M[12]; writes ignored.
- `mie` (0x304): only bits 3, 7 and 11 are writable.
- `mtvec` (0x305): direct mode only; bits [1:0] read 0.
- `mscratch` (0x340): full 64-bit.
- `mepc` (0x341): bits [1:0] read 0.
- `mcause` (0x342) and `mtval` (0x343): full 64-bit.
- `mip` (0x344): read-only; MSIP[3], MTIP[7] and MEIP[11] reflect the input pins directly.
- `mcycle` (0xB00) and `minstret` (0xB02): writable 64-bit counters. `cycle` (0xC00) and `instret` (0xC02) are read-only aliases of them.
- `mvendorid`, `marchid`, `mimpid` (0xF11–0xF13) read 0. `mhartid` (0xF14) reads HART_ID.

Write path:
- On `wvalid`, the register at `waddr` takes `wdata`, masked to its writable bits.

Trap entry (`trap_i`):
- `mepc` <= `trap_pc_i` & ~3.
- `mcause` <= `trap_cause_i`.
- `mtval` <= `trap_tval_i`.
- MPIE <= MIE, then MIE <= 0.

Return (`mret_i`):
- MIE <= MPIE.
- MPIE <= 1.

Priority when events coincide, per register: `trap_i` > `mret_i` > CSR write.
- Example: a write to `mstatus` in the same cycle as `trap_i` is lost.
- A write to `mscratch` in that same cycle still lands, because the trap does not touch `mscratch`.

Counters:
- `mcycle` increments by 1 every cycle unless it is written that cycle; a write replaces the value with no increment.
- `minstret` increments by `retire_cnt_i` unless it is written that cycle.
- Both counters wrap modulo 2^64 with no flag.

Interrupts:
- pending = `mie` & `mip`.
- `irq_o` = MIE & |pending.
- `irq_cause_o` = {1'b1, 63'(code)}, where code is 11, 3 or 7 in priority order MEI > MSI > MTI. It is 0 when `irq_o` is 0.

## Timing
- Reads are purely combinational from registered state. There is no write-to-read bypass: a write becomes visible on `rdata` the cycle after `wvalid`. The FU's single-entry write queue guarantees no RaW overlap.
- `mip`, `irq_o` and `irq_cause_o` follow the interrupt pins combinationally, with zero-cycle latency.
- Reset (`rst` high at an edge):
  - `mstatus` MIE = MPIE = 0.
  - `mtvec` = MTVEC_RESET.
  - All other writable CSRs and both counters = 0.
  - `trap_vec_o` = MTVEC_RESET; `epc_o` = 0; `irq_o` = 0.
- Reset overrides any same-cycle `wvalid`, `trap_i`, `mret_i` or retire count.
- The first `mcycle` increment happens at the first edge after `rst` deasserts, so a read in the first post-reset cycle returns 0.

## Test plan
- Reset, then read 0x300, 0x305, 0xF14 (HART_ID=2) and 0xB00 in the first cycle -> 64'h1800, 64'h8000_0000, 2, 0.
- Write 0x305 = 64'h1003 -> next-cycle read and `trap_vec_o` both 64'h1000. Write 0x344 = all-ones -> `mip` is unchanged and equals the pin values.
- MIE=1, then `trap_i` with pc 64'h2006, cause 2, tval 5 in the same cycle as a write of `mstatus`=0x8 -> `mepc`=0x2004, `mcause`=2, `mtval`=5, `mstatus`=0x1880. Then `mret_i` -> `mstatus`=0x1888.
- `mie`=0x888, MIE=1, raise `irq_mtip_i` and `irq_msip_i` -> `irq_o`=1, `irq_cause_o`=64'h8000_0000_0000_0003. Raise `irq_meip_i` as well -> code 11. Clear MIE -> `irq_o`=0.
- `retire_cnt_i`=3 for 4 cycles -> `minstret`=12. Write `minstret`=100 while `retire_cnt_i`=2 -> next read is 100.
- Write `mcycle`=64'hFFFF_FFFF_FFFF_FFFF -> the read in the next cycle returns all-ones and the read one cycle later returns 0. Read 0x7C0 -> 0.
